// File: rtl/uart_pkg.sv
// UART shared definitions: frame states, line levels, prescale floor.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic EVEN      = 1'b0;
  localparam logic ODD       = 1'b1;

  localparam int PRESCALE_MIN = 4;

  function automatic logic [4:0] clamp_ps(
    input logic [4:0] ps,
    input logic [4:0] ps_min
  );
    return (ps < ps_min) ? ps_min : ps;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// System-side word port of the UART transmitter.
// master = data source, slave = transmitter.
interface uart_tx_frame_if #(
  parameter int width = 8
);

  logic [width-1:0] P_Data;
  logic             Data_valid;
  logic             Parity_EN;
  logic             Parity_type;
  logic [4:0]       Prescale;
  logic             TX_OUT;
  logic             Busy;

  modport master (
    output P_Data,
    output Data_valid,
    output Parity_EN,
    output Parity_type,
    output Prescale,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_Data,
    input  Data_valid,
    input  Parity_EN,
    input  Parity_type,
    input  Prescale,
    output TX_OUT,
    output Busy
  );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter and bit index for the UART transmitter.
// bit_done marks the last cycle of each bit period.
module uart_tx_bit_timer #(
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    ps,
  input  logic          load,
  input  logic          en,
  output logic          bit_done,
  output logic [IW-1:0] bit_idx
);

  logic [4:0] cnt_q;

  assign bit_done = (cnt_q == ps - 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      bit_idx <= '0;
    end else if (load) begin
      cnt_q   <= '0;
      bit_idx <= '0;
    end else if (en) begin
      if (bit_done) begin
        cnt_q   <= '0;
        bit_idx <= bit_idx + 1'b1;
      end else begin
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, data LSB first, optional parity, stop.
// Every output comes straight from a flop.
module uart_tx_frame #(
  parameter int width        = 8,
  parameter int PRESCALE_MIN = 4
) (
  input logic           CLK,
  input logic           Reset,
  uart_tx_frame_if.slave bus
);

  import uart_pkg::*;

  localparam int IW = (width > 1) ? $clog2(width) : 1;
  localparam logic [4:0]    PS_MIN = 5'(PRESCALE_MIN);
  localparam logic [IW-1:0] LAST   = IW'(width - 1);

  uart_state_t state_q, state_n;

  logic [width-1:0] sh_q, sh_nx;
  logic [4:0]       ps_q;
  logic             pen_q, par_q;
  logic             tx_q, tx_n;
  logic             busy_q, busy_n;
  logic             cap, load, shift;
  logic             bit_done;
  logic [IW-1:0]    bit_idx;

  assign sh_nx      = sh_q >> 1;
  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

  uart_tx_bit_timer #(
    .IW(IW)
  ) u_timer (
    .clk     (CLK),
    .reset   (Reset),
    .ps      (ps_q),
    .load    (load),
    .en      (state_q != IDLE),
    .bit_done(bit_done),
    .bit_idx (bit_idx)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
      sh_q    <= '0;
      ps_q    <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      if (cap) begin
        sh_q  <= bus.P_Data;
        ps_q  <= clamp_ps(bus.Prescale, PS_MIN);
        pen_q <= bus.Parity_EN;
        par_q <= (^bus.P_Data) ^ (bus.Parity_type == ODD);
      end else if (shift) begin
        sh_q <= sh_nx;
      end
    end
  end

  // tx_n is the level of the bit that starts at this edge
  always_comb begin
    state_n = state_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    cap     = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Data_valid) begin
          cap     = 1'b1;
          load    = 1'b1;
          state_n = START;
          tx_n    = START_BIT;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          load    = 1'b1;
          state_n = DATA;
          tx_n    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == LAST) begin
            state_n = pen_q ? PARITY : STOP;
            tx_n    = pen_q ? par_q : STOP_BIT;
          end else begin
            shift = 1'b1;
            tx_n  = sh_nx[0];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_n = STOP;
          tx_n    = STOP_BIT;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_n = IDLE;
          tx_n    = STOP_BIT;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = STOP_BIT;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter serializing one parallel word per frame onto the serial line consumed by the UART receiver. It sits directly upstream of the receiver and uses the same frame format: start 0, data LSB first, optional parity, stop 1. Each bit is held for Prescale CLK cycles, so TX and RX share one system clock and one Prescale setting. Accepts words via a valid/busy handshake from the system-side data source.

Parameters:
width, 8, data word width in bits
PRESCALE_MIN, 4, smallest bit period in CLK cycles; smaller Prescale values are clamped to this

Ports:
CLK  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
P_Data  input  width  parallel word to transmit
Data_valid  input  1  word request; accepted only when Busy=0
Parity_EN  input  1  1 = parity bit inserted after data
Parity_type  input  1  0 = even parity, 1 = odd parity
Prescale  input  5  CLK cycles per serial bit (4..31)
TX_OUT  output  1  serial line, idle high
Busy  output  1  1 from the accept edge until the frame's stop bit ends

Behaviour:
- Reset: synchronous, active-high. At the next CLK edge: TX_OUT=1, Busy=0, state IDLE, counters=0. Same action mid-frame, with no partial stop bit.
- States: IDLE -> START -> DATA -> (PARITY if Parity_EN) -> STOP -> IDLE.
- Accept: at the edge where state=IDLE and Data_valid=1, capture P_Data, Parity_EN, Parity_type and the clamped Prescale. Changes to these inputs mid-frame have no effect.
- Accept edge: state moves to START, TX_OUT=0 and Busy=1, all registered and visible immediately after that edge (latency 0 cycles from accept edge).
- Bit timer: counts 0..Ps-1 for each bit, where Ps = max(Prescale, PRESCALE_MIN). The bit index advances when the timer reaches Ps-1.
- START: Ps cycles of 0.
- DATA: width bits, bit index 0..width-1, driving captured_data[idx] (LSB first), Ps cycles each.
- PARITY: computed from the captured data as reduction XOR. Even parity: TX_OUT = XOR; odd parity: TX_OUT = ~XOR. Held Ps cycles.
- STOP: TX_OUT=1 for Ps cycles. At the end edge, state returns to IDLE and Busy=0.
- Frame length: Ps*(width+2+Parity_EN) cycles from accept edge to Busy falling.
- Data_valid while Busy=1: ignored, with no queueing. The source must hold Data_valid until it sees Busy=0.
- Back-to-back frames: the earliest next accept is the edge one cycle after Busy falls, so the line stays high for at least Ps+1 cycles between frames.
- Data_valid held high continuously: frames repeat with that 1-cycle IDLE gap.
- TX_OUT is driven directly from a flop; there is no combinational path from any input to any output.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - constants START_BIT=0, STOP_BIT=1, EVEN=0, ODD=1;
  - PRESCALE_MIN.
  - The receiver uses the same package.
- One sub-module, uart_tx_bit_timer: takes a clamped prescale, a load signal and an enable. It outputs bit_done (timer == Ps-1) and the bit index, and wraps to 0 on load.
- FSM, capture registers and parity logic stay in the top module.

Test Plan:
- Word 8'd10, Parity_EN=1, even parity, Prescale=8, CLK period 20 ns: TX_OUT sequence 0,0,1,0,1,0,0,0,0,0,1, each bit 160 ns; Busy high for 88 cycles; matching receiver shows P_Data=10 with no errors.
- Word 8'd100, odd parity: parity bit = 0 (three ones); frame 0_00100110_0_1 on the line, LSB first.
- Parity_EN=0, word 8'd100, Prescale=16: 10-bit frame, Busy high for 160 cycles, no parity slot.
- Data_valid held high, words 8'hFF then 8'h00: second start bit begins exactly Ps+1 cycles after the first stop bit begins; a Data_valid pulse mid-frame is ignored.
- Prescale=2: bits last 4 cycles (clamped). Changing Prescale from 8 to 16 mid-frame leaves the current frame at 8 cycles per bit.
- Reset asserted during the DATA state: at the next edge TX_OUT=1 and Busy=0; a new word accepted afterwards transmits a full, correct frame.
